// File: rtl/sccb_cfg_sequencer.sv
// Walks a combinational camera-register LUT and issues each entry as an SCCB/I2C write.
// Supports a power-up wait, in-table delay entries, optional read-back verify with bounded retry, and done/error status.
module sccb_cfg_sequencer #(
  parameter int unsigned IDX_W            = 10,
  parameter int unsigned CLK_FREQ_HZ      = 50_000_000,
  parameter int unsigned POWERUP_DELAY_MS = 20,
  parameter int unsigned MAX_RETRY        = 3,
  parameter int unsigned VERIFY           = 0,
  parameter logic [7:0]  END_DEV          = 8'hff,
  parameter logic [7:0]  DELAY_DEV        = 8'hfe
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [IDX_W-1:0] lut_index,
  input  logic [31:0]      lut_data,
  output logic             i2c_req,
  output logic             i2c_read,
  output logic [7:0]       i2c_dev_addr,
  output logic [15:0]      i2c_reg_addr,
  output logic [7:0]       i2c_wdata,
  input  logic             i2c_ack,
  input  logic             i2c_err,
  input  logic [7:0]       i2c_rdata,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_index
);

  localparam int unsigned CYC_PER_MS = CLK_FREQ_HZ / 1000;
  localparam int unsigned CYC_W      = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
  localparam int unsigned RETRY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_PWR_WAIT, S_FETCH, S_DECODE, S_WR, S_WR_WAIT,
    S_RD, S_RD_WAIT, S_DLY, S_DONE, S_ERR
  } state_t;

  state_t             r_state, w_state_nx;
  logic [IDX_W-1:0]   r_lut_index, w_lut_index_nx;
  logic [31:0]        r_entry, w_entry_nx;
  logic [RETRY_W-1:0] r_retry, w_retry_nx;
  logic [CYC_W-1:0]   r_cyc, w_cyc_nx;
  logic [15:0]        r_ms, w_ms_nx;
  logic               r_req, w_req_nx;
  logic               r_read, w_read_nx;
  logic [7:0]         r_dev, w_dev_nx;
  logic [15:0]        r_reg, w_reg_nx;
  logic [7:0]         r_wdata, w_wdata_nx;
  logic               r_busy, w_busy_nx;
  logic               r_done, w_done_nx;
  logic               r_error, w_error_nx;
  logic [IDX_W-1:0]   r_err_index, w_err_index_nx;

  logic               w_adv, w_fail, w_tick_last, w_tmr_done;
  logic [15:0]        w_ms_target;

  // Shared ms timer: power-up wait or the delay field of the current entry
  assign w_ms_target = (r_state == S_DLY) ? r_entry[23:8] : 16'(POWERUP_DELAY_MS);
  assign w_tick_last = (r_cyc == CYC_W'(CYC_PER_MS - 1));
  assign w_tmr_done  = (w_ms_target == 16'd0) ||
                       (w_tick_last && (r_ms == (w_ms_target - 16'd1)));

  always_comb begin
    w_state_nx     = r_state;
    w_lut_index_nx = r_lut_index;
    w_entry_nx     = r_entry;
    w_retry_nx     = r_retry;
    w_cyc_nx       = r_cyc;
    w_ms_nx        = r_ms;
    w_req_nx       = r_req;
    w_read_nx      = r_read;
    w_dev_nx       = r_dev;
    w_reg_nx       = r_reg;
    w_wdata_nx     = r_wdata;
    w_busy_nx      = r_busy;
    w_done_nx      = r_done;
    w_error_nx     = r_error;
    w_err_index_nx = r_err_index;
    w_adv          = 1'b0;
    w_fail         = 1'b0;

    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          w_lut_index_nx = '0;
          w_retry_nx     = '0;
          w_cyc_nx       = '0;
          w_ms_nx        = '0;
          w_done_nx      = 1'b0;
          w_error_nx     = 1'b0;
          w_busy_nx      = 1'b1;
          w_state_nx     = S_PWR_WAIT;
        end
      end
      S_PWR_WAIT, S_DLY: begin
        if (w_tmr_done) begin
          if (r_state == S_PWR_WAIT) w_state_nx = S_FETCH;
          else                       w_adv      = 1'b1;
        end else if (w_tick_last) begin
          w_cyc_nx = '0;
          w_ms_nx  = r_ms + 16'd1;
        end else begin
          w_cyc_nx = r_cyc + CYC_W'(1);
        end
      end
      S_FETCH: begin
        w_entry_nx = lut_data;
        w_state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (r_entry[31:24] == END_DEV) begin
          w_state_nx = S_DONE;
          w_done_nx  = 1'b1;
          w_busy_nx  = 1'b0;
        end else if (r_entry[31:24] == 8'h00) begin
          w_state_nx     = S_ERR;
          w_error_nx     = 1'b1;
          w_err_index_nx = r_lut_index;
          w_busy_nx      = 1'b0;
        end else if (r_entry[31:24] == DELAY_DEV) begin
          if (r_entry[23:8] == 16'd0) begin
            w_adv = 1'b1;
          end else begin
            w_cyc_nx   = '0;
            w_ms_nx    = '0;
            w_state_nx = S_DLY;
          end
        end else begin
          w_dev_nx   = r_entry[31:24];
          w_reg_nx   = r_entry[23:8];
          w_wdata_nx = r_entry[7:0];
          w_req_nx   = 1'b1;
          w_read_nx  = 1'b0;
          w_state_nx = S_WR;
        end
      end
      S_WR, S_WR_WAIT: begin
        w_state_nx = S_WR_WAIT;
        if (i2c_err) begin
          w_req_nx = 1'b0;
          w_fail   = 1'b1;
        end else if (i2c_ack) begin
          w_req_nx = 1'b0;
          if (VERIFY != 0) w_state_nx = S_RD;
          else             w_adv      = 1'b1;
        end
      end
      S_RD: begin
        w_req_nx   = 1'b1;
        w_read_nx  = 1'b1;
        w_state_nx = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (i2c_err) begin
          w_req_nx  = 1'b0;
          w_read_nx = 1'b0;
          w_fail    = 1'b1;
        end else if (i2c_ack) begin
          w_req_nx  = 1'b0;
          w_read_nx = 1'b0;
          if (i2c_rdata == r_wdata) w_adv  = 1'b1;
          else                      w_fail = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    if (w_adv) begin
      w_retry_nx = '0;
      if (r_lut_index == '1) begin
        w_state_nx = S_DONE;
        w_done_nx  = 1'b1;
        w_busy_nx  = 1'b0;
      end else begin
        w_lut_index_nx = r_lut_index + IDX_W'(1);
        w_state_nx     = S_FETCH;
      end
    end

    // Retries re-fetch the same entry so req is guaranteed to drop between attempts
    if (w_fail) begin
      if (r_retry < RETRY_W'(MAX_RETRY)) begin
        w_retry_nx = r_retry + RETRY_W'(1);
        w_state_nx = S_FETCH;
      end else begin
        w_state_nx     = S_ERR;
        w_error_nx     = 1'b1;
        w_err_index_nx = r_lut_index;
        w_busy_nx      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_lut_index <= '0;
      r_entry     <= '0;
      r_retry     <= '0;
      r_cyc       <= '0;
      r_ms        <= '0;
      r_req       <= 1'b0;
      r_read      <= 1'b0;
      r_dev       <= '0;
      r_reg       <= '0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_index <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_lut_index <= w_lut_index_nx;
      r_entry     <= w_entry_nx;
      r_retry     <= w_retry_nx;
      r_cyc       <= w_cyc_nx;
      r_ms        <= w_ms_nx;
      r_req       <= w_req_nx;
      r_read      <= w_read_nx;
      r_dev       <= w_dev_nx;
      r_reg       <= w_reg_nx;
      r_wdata     <= w_wdata_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
      r_error     <= w_error_nx;
      r_err_index <= w_err_index_nx;
    end
  end

  assign lut_index    = r_lut_index;
  assign i2c_req      = r_req;
  assign i2c_read     = r_read;
  assign i2c_dev_addr = r_dev;
  assign i2c_reg_addr = r_reg;
  assign i2c_wdata    = r_wdata;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign err_index    = r_err_index;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Bench for sccb_cfg_sequencer: two instances (write-only and verify), a shared I2C responder,
// and a table-walking reference model feeding a transaction scoreboard.
module tb_sccb_cfg_sequencer;

  localparam int unsigned IDX_W     = 4;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned MAX_RETRY = 2;
  localparam int          PWR_LAT   = 12;
  localparam int          TMO       = 5000;

  typedef struct packed {
    logic        rd;
    logic [7:0]  dev;
    logic [15:0] ra;
    logic [7:0]  wd;
  } txn_t;

  logic             clk = 1'b0;
  logic             rst_n, start_s, sel;
  logic             start0, start1;
  logic             i2c_ack, i2c_err;
  logic [7:0]       i2c_rdata;
  logic [31:0]      lut_data0, lut_data1;
  logic [IDX_W-1:0] idx0, idx1, eidx0, eidx1;
  logic             req0, req1, rd0, rd1, busy0, busy1, done0, done1, error0, error1;
  logic [7:0]       dev0, dev1, wd0, wd1;
  logic [15:0]      reg0, reg1;

  logic             m_req, m_rd, m_busy, m_done, m_error;
  logic [7:0]       m_dev, m_wd;
  logic [15:0]      m_reg;
  logic [IDX_W-1:0] m_idx, m_eidx;

  logic [31:0] tbl [DEPTH];
  int          fail_n [DEPTH];
  bit          rd_bad [DEPTH];
  int          att [DEPTH];
  int          ack_dly;

  txn_t exp_q[$];
  txn_t mon_exp;
  int   rise_t[$];
  int   fall_t[$];
  int   cyc = 0;
  int   t_start;
  int   checks = 0;
  int   errors = 0;
  bit   exp_done, exp_error;
  int   exp_eidx;
  logic mon_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign start0    = start_s & ~sel;
  assign start1    = start_s & sel;
  assign lut_data0 = tbl[idx0];
  assign lut_data1 = tbl[idx1];

  assign m_req   = sel ? req1   : req0;
  assign m_rd    = sel ? rd1    : rd0;
  assign m_dev   = sel ? dev1   : dev0;
  assign m_reg   = sel ? reg1   : reg0;
  assign m_wd    = sel ? wd1    : wd0;
  assign m_busy  = sel ? busy1  : busy0;
  assign m_done  = sel ? done1  : done0;
  assign m_error = sel ? error1 : error0;
  assign m_idx   = sel ? idx1   : idx0;
  assign m_eidx  = sel ? eidx1  : eidx0;

  sccb_cfg_sequencer #(.IDX_W(IDX_W), .CLK_FREQ_HZ(10_000), .POWERUP_DELAY_MS(1),
                       .MAX_RETRY(MAX_RETRY), .VERIFY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .lut_index(idx0), .lut_data(lut_data0),
    .i2c_req(req0), .i2c_read(rd0), .i2c_dev_addr(dev0), .i2c_reg_addr(reg0),
    .i2c_wdata(wd0), .i2c_ack(i2c_ack), .i2c_err(i2c_err), .i2c_rdata(i2c_rdata),
    .busy(busy0), .done(done0), .error(error0), .err_index(eidx0)
  );

  sccb_cfg_sequencer #(.IDX_W(IDX_W), .CLK_FREQ_HZ(10_000), .POWERUP_DELAY_MS(1),
                       .MAX_RETRY(MAX_RETRY), .VERIFY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .lut_index(idx1), .lut_data(lut_data1),
    .i2c_req(req1), .i2c_read(rd1), .i2c_dev_addr(dev1), .i2c_reg_addr(reg1),
    .i2c_wdata(wd1), .i2c_ack(i2c_ack), .i2c_err(i2c_err), .i2c_rdata(i2c_rdata),
    .busy(busy1), .done(done1), .error(error1), .err_index(eidx1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk the table by its rules and list every transaction the sequencer must issue
  task automatic build_model(input bit verify);
    int    idx;
    int    a;
    bit    fin;
    bit    ok;
    logic [31:0] e;
    exp_q.delete();
    exp_done = 0; exp_error = 0; exp_eidx = 0;
    idx = 0; fin = 0;
    while (!fin) begin
      e = tbl[idx];
      if (e[31:24] == 8'hff) begin
        exp_done = 1; fin = 1;
      end else if (e[31:24] == 8'h00) begin
        exp_error = 1; exp_eidx = idx; fin = 1;
      end else begin
        ok = (e[31:24] == 8'hfe);
        a  = 0;
        while (!ok && !fin) begin
          exp_q.push_back(txn_t'({1'b0, e}));
          if (a >= fail_n[idx]) begin
            if (!verify) ok = 1;
            else begin
              exp_q.push_back(txn_t'({1'b1, e}));
              ok = !rd_bad[idx];
            end
          end
          if (!ok) begin
            if (a < int'(MAX_RETRY)) a++;
            else begin exp_error = 1; exp_eidx = idx; fin = 1; end
          end
        end
        if (!fin) begin
          if (idx == DEPTH - 1) begin exp_done = 1; fin = 1; end
          else idx++;
        end
      end
    end
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < DEPTH; i++) begin
      tbl[i] = 32'h0; fail_n[i] = 0; rd_bad[i] = 1'b0;
    end
  endtask

  // I2C master model: acks after a delay, errors the first fail_n writes of an entry
  initial begin
    int  cnt;
    bit  pend;
    int  ri;
    i2c_ack = 1'b0; i2c_err = 1'b0; i2c_rdata = 8'h00;
    cnt = 0; pend = 0;
    forever begin
      @(negedge clk);
      i2c_ack = 1'b0; i2c_err = 1'b0;
      if (!m_req) begin
        pend = 0; cnt = 0;
      end else begin
        if (!pend) begin
          pend = 1;
          cnt  = (ack_dly > 0) ? ack_dly : int'($urandom_range(1, 6));
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            ri = int'(m_idx);
            if (!m_rd) begin
              if (att[ri] < fail_n[ri]) begin
                i2c_err = 1'b1;
                i2c_ack = 1'($urandom_range(0, 1));
              end else begin
                i2c_ack = 1'b1;
              end
              att[ri]++;
            end else begin
              i2c_ack   = 1'b1;
              i2c_rdata = rd_bad[ri] ? (tbl[ri][7:0] ^ 8'h5a) : tbl[ri][7:0];
            end
          end
        end
      end
    end
  end

  // Monitor: each new request is popped against the scoreboard
  always @(negedge clk) begin
    if (m_req && !mon_prev) begin
      rise_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL txn_extra actual rd=%0b dev=%h reg=%h wd=%h required none",
                 m_rd, m_dev, m_reg, m_wd);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("txn", 64'({m_rd, m_dev, m_reg, m_wd}), 64'(mon_exp));
      end
    end
    if (!m_req && mon_prev) fall_t.push_back(cyc);
    mon_prev = m_req;
  end

  task automatic run_seq(input string name, input bit v, input int dly);
    int n;
    sel = v; ack_dly = dly;
    for (int i = 0; i < DEPTH; i++) att[i] = 0;
    build_model(v);
    rise_t.delete(); fall_t.delete();
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0; t_start = cyc;
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    n = 0;
    while (!(m_done || m_error) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual busy=%0b required done or error", name, m_busy);
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
    end else begin
      chk({name, "_done"},  64'(m_done),  64'(exp_done));
      chk({name, "_error"}, 64'(m_error), 64'(exp_error));
      chk({name, "_busy"},  64'(m_busy),  64'd0);
      chk({name, "_left"},  64'(exp_q.size()), 64'd0);
      if (exp_error) chk({name, "_eidx"}, 64'(m_eidx), 64'(exp_eidx));
      if (!(tbl[0][31:24] inside {8'h00, 8'hfe, 8'hff}))
        chk({name, "_lat"}, 64'((rise_t.size() > 0) ? (rise_t[0] - t_start) : -1),
            64'(PWR_LAT));
    end
  endtask

  initial begin
    int n;
    int gap;
    int term;
    rst_n = 1'b0; start_s = 1'b0; sel = 1'b0; ack_dly = 5;
    clear_cfg();
    for (int i = 0; i < DEPTH; i++) att[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_outs0", 64'({idx0, req0, rd0, dev0, reg0, wd0, busy0, done0, error0, eidx0}), 64'd0);
    chk("rst_outs1", 64'({idx1, req1, rd1, dev1, reg1, wd1, busy1, done1, error1, eidx1}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two writes then end marker
    clear_cfg();
    tbl[0] = 32'h78300802; tbl[1] = 32'h78310302; tbl[2] = 32'hffffffff;
    run_seq("t1", 1'b0, 5);

    // Delay entry between two writes
    clear_cfg();
    tbl[0] = 32'h78300802; tbl[1] = 32'hfe000300; tbl[2] = 32'h78310302; tbl[3] = 32'hffffffff;
    run_seq("t2", 1'b0, 5);
    gap = (rise_t.size() > 1 && fall_t.size() > 0) ? (rise_t[1] - fall_t[0]) : 0;
    chk("t2_gap_min30", 64'((gap >= 30) ? 30 : gap), 64'd30);

    // Persistent write error at index 4
    clear_cfg();
    for (int i = 0; i < 5; i++) tbl[i] = {8'h42, 8'h10, 8'(i), 8'(8'h20 + i)};
    tbl[5] = 32'hffffffff;
    fail_n[4] = 99;
    run_seq("t3", 1'b0, 0);
    chk("t3_nreq", 64'(rise_t.size()), 64'd7);

    // Verify: matching read-back, then mismatching read-back
    clear_cfg();
    tbl[0] = 32'h78300802; tbl[1] = 32'h78310302; tbl[2] = 32'hffffffff;
    run_seq("t4a", 1'b1, 0);
    rd_bad[1] = 1'b1;
    run_seq("t4b", 1'b1, 0);

    // Unterminated table
    clear_cfg();
    tbl[0] = 32'h21000111; tbl[1] = 32'h21000222; tbl[2] = 32'h21000333;
    run_seq("t5", 1'b0, 0);

    // Full table, zero-ms delay, transient errors: finishes on last index
    clear_cfg();
    for (int i = 0; i < DEPTH; i++) tbl[i] = {8'h60, 8'h01, 8'(i), 8'(i * 3)};
    tbl[5] = 32'hfe000000;
    fail_n[7] = 2; fail_n[15] = 1;
    run_seq("full0", 1'b0, 0);
    run_seq("full1", 1'b1, 0);

    // Reset while a request is outstanding, then restart from index 0
    clear_cfg();
    tbl[0] = 32'h78300802; tbl[1] = 32'h78310302; tbl[2] = 32'hffffffff;
    sel = 1'b0; ack_dly = 5;
    for (int i = 0; i < DEPTH; i++) att[i] = 0;
    build_model(1'b0);
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    n = 0;
    while (!m_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_req_seen", 64'(m_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", 64'({idx0, req0, rd0, dev0, reg0, wd0, busy0, done0, error0, eidx0}), 64'd0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    run_seq("t6", 1'b0, 5);

    // Randomised tables and master behaviour
    for (int r = 0; r < 16; r++) begin
      clear_cfg();
      for (int i = 0; i < DEPTH; i++) begin
        if ($urandom_range(0, 9) == 0)
          tbl[i] = {8'hfe, 16'($urandom_range(0, 2)), 8'h00};
        else
          tbl[i] = {8'($urandom_range(1, 253)), 16'($urandom), 8'($urandom)};
        fail_n[i] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
        rd_bad[i] = ($urandom_range(0, 15) == 0);
      end
      term = int'($urandom_range(1, DEPTH));
      if (term < DEPTH) tbl[term] = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'hffffffff;
      run_seq("rnd", 1'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
